// File: rtl/reg_list_sequencer.sv
// LDM/STM block-transfer sequencer: walks a 16-bit register list, one memory beat per register.
// Optional base writeback is compiled in when REG_SEQ_WRITEBACK_EN is defined.
module reg_list_sequencer #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [15:0]       reg_list,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [3:0]        base_reg,
    input  logic              load,
    input  logic              up,
    input  logic              pre,
    input  logic              wback,
    output logic              busy,
    output logic              done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [3:0]        rf_read_num,
    input  logic [DATA_W-1:0] rf_read_data,
    output logic              rf_write_en,
    output logic [3:0]        rf_write_num,
    output logic [DATA_W-1:0] rf_write_data
);

    typedef enum logic [1:0] {StIdle, StXfer, StWb, StFin} state_e;

    state_e            state_q, state_d;
    logic [15:0]       list_q, list_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] final_q, final_d;
    logic [3:0]        base_reg_q, base_reg_d;
    logic              load_q, load_d;
    logic              wb_act_q, wb_act_d;
    logic              wen_q, wen_d;
    logic [3:0]        wnum_q, wnum_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic [4:0]        count;
    logic [ADDR_W-1:0] span;
    logic [3:0]        cur_reg;
    logic              wb_req;

    always_comb begin
        count = '0;
        for (int i = 0; i < 16; i++) begin
            count = count + 5'(reg_list[i]);
        end
    end

    assign span = ADDR_W'({count, 2'b00});

    // Lowest set bit of the remaining list is the register serviced by the current beat.
    always_comb begin
        cur_reg = '0;
        for (int i = 15; i >= 0; i--) begin
            if (list_q[i]) begin
                cur_reg = 4'(i);
            end
        end
    end

`ifdef REG_SEQ_WRITEBACK_EN
    // A loaded base register takes precedence over the computed writeback value.
    assign wb_req = wback && (count != 5'd0) && !(load && reg_list[base_reg]);
`else
    logic unused_wback;
    assign unused_wback = wback;
    assign wb_req       = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        list_d     = list_q;
        addr_d     = addr_q;
        final_d    = final_q;
        base_reg_d = base_reg_q;
        load_d     = load_q;
        wb_act_d   = wb_act_q;
        wen_d      = 1'b0;
        wnum_d     = wnum_q;
        wdata_d    = wdata_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    list_d     = reg_list;
                    base_reg_d = base_reg;
                    load_d     = load;
                    wb_act_d   = wb_req;
                    final_d    = up ? base_addr + span : base_addr - span;
                    if (up) begin
                        addr_d = pre ? base_addr + ADDR_W'(4) : base_addr;
                    end else begin
                        addr_d = pre ? base_addr - span : base_addr - span + ADDR_W'(4);
                    end
                    state_d = (count == 5'd0) ? StWb : StXfer;
                end
            end
            StXfer: begin
                if (mem_ack) begin
                    list_d = list_q & (list_q - 16'd1);
                    addr_d = addr_q + ADDR_W'(4);
                    if (load_q) begin
                        wen_d   = 1'b1;
                        wnum_d  = cur_reg;
                        wdata_d = mem_rdata;
                    end
                    if (list_d == 16'd0) begin
                        state_d = StWb;
                    end
                end
            end
            StWb: begin
                state_d = StFin;
                if (wb_act_q) begin
                    wen_d   = 1'b1;
                    wnum_d  = base_reg_q;
                    wdata_d = final_q;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= StIdle;
            list_q     <= '0;
            addr_q     <= '0;
            final_q    <= '0;
            base_reg_q <= '0;
            load_q     <= 1'b0;
            wb_act_q   <= 1'b0;
            wen_q      <= 1'b0;
            wnum_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            list_q     <= list_d;
            addr_q     <= addr_d;
            final_q    <= final_d;
            base_reg_q <= base_reg_d;
            load_q     <= load_d;
            wb_act_q   <= wb_act_d;
            wen_q      <= wen_d;
            wnum_q     <= wnum_d;
            wdata_q    <= wdata_d;
        end
    end

    assign busy          = (state_q == StXfer) || (state_q == StWb);
    assign done          = (state_q == StFin);
    assign mem_req       = (state_q == StXfer);
    assign mem_we        = mem_req && !load_q;
    assign mem_addr      = addr_q;
    assign mem_wdata     = rf_read_data;
    assign rf_read_num   = cur_reg;
    assign rf_write_en   = wen_q;
    assign rf_write_num  = wnum_q;
    assign rf_write_data = wdata_q;

endmodule

// File: tb/tb_reg_list_sequencer.sv
// Scoreboard bench for reg_list_sequencer: stimulus pushes expected beats/writes/done records,
// a negedge monitor pops and compares them. Mirrors REG_SEQ_WRITEBACK_EN in its model.
module tb_reg_list_sequencer;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  num;
        logic [31:0] wdata;
    } beat_t;

    typedef struct {
        logic [3:0]  num;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        int start_cnt;
        int n;
    } done_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] reg_list = '0;
    logic [31:0] base_addr = '0;
    logic [3:0]  base_reg = '0;
    logic        load = 1'b0;
    logic        up = 1'b0;
    logic        pre = 1'b0;
    logic        wback = 1'b0;
    logic        busy, done, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack = 1'b0;
    logic [3:0]  rf_read_num;
    logic [31:0] rf_read_data;
    logic        rf_write_en;
    logic [3:0]  rf_write_num;
    logic [31:0] rf_write_data;

    beat_t       beat_q[$];
    wr_t         wr_q[$];
    done_t       done_q[$];
    logic [31:0] env_rf[16];
    logic [31:0] ref_rf[16];
    int          checks = 0;
    int          failures = 0;
    int          cycle_cnt = 0;
    int          waits = 0;
    int          beat_waits = 0;
    int          ack_mode = 0;
    bit          quiet = 1'b0;

    reg_list_sequencer #(.ADDR_W(32), .DATA_W(32)) dut (
        .clock(clock), .reset(reset), .start(start), .reg_list(reg_list),
        .base_addr(base_addr), .base_reg(base_reg), .load(load), .up(up), .pre(pre),
        .wback(wback), .busy(busy), .done(done), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .rf_read_num(rf_read_num), .rf_read_data(rf_read_data), .rf_write_en(rf_write_en),
        .rf_write_num(rf_write_num), .rf_write_data(rf_write_data)
    );

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (a == 32'h1FF8) return 32'h11;
        if (a == 32'h1FFC) return 32'h22;
        return {a[15:0], ~a[15:0]} ^ 32'h3C3C_0000;
    endfunction

    assign mem_rdata    = mem_val(mem_addr);
    assign rf_read_data = env_rf[rf_read_num];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    initial forever #5 clock = ~clock;

    always @(posedge clock) cycle_cnt <= cycle_cnt + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // Monitor and memory responder.
    beat_t mon_b;
    wr_t   mon_w;
    done_t mon_d;
    bit    ack_now;
    initial forever begin
        @(negedge clock);
        case (ack_mode)
            1:       ack_now = 1'b1;
            2:       ack_now = (beat_waits >= 3);
            default: ack_now = ($urandom_range(0, 2) != 0);
        endcase
        if (mem_req) beat_waits = ack_now ? 0 : beat_waits + 1;
        if (reset && !quiet) begin
            if (mem_req) begin
                check("busy_in_xfer", 32'(busy), 32'd1);
                if (beat_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat actual=%h expected=none", mem_addr);
                end else begin
                    mon_b = beat_q[0];
                    check("beat_addr", mem_addr, mon_b.addr);
                    check("beat_we", 32'(mem_we), 32'(mon_b.we));
                    check("beat_rnum", 32'(rf_read_num), 32'(mon_b.num));
                    if (mon_b.we) check("beat_wdata", mem_wdata, mon_b.wdata);
                    if (ack_now) void'(beat_q.pop_front());
                    else waits++;
                end
            end
            if (rf_write_en) begin
                if (wr_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rf_write actual=r%0d expected=none", rf_write_num);
                end else begin
                    mon_w = wr_q.pop_front();
                    check("rf_write_num", 32'(rf_write_num), 32'(mon_w.num));
                    check("rf_write_data", rf_write_data, mon_w.data);
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done actual=1 expected=0");
                end else begin
                    mon_d = done_q.pop_front();
                    check("done_latency", 32'(cycle_cnt - mon_d.start_cnt),
                          32'(mon_d.n + 2 + waits));
                    check("busy_at_done", 32'(busy), 32'd0);
                    check("leftover_beats", 32'(beat_q.size()), 32'd0);
                    check("leftover_writes", 32'(wr_q.size()), 32'd0);
                end
                waits = 0;
            end
        end
        if (rf_write_en) env_rf[rf_write_num] = rf_write_data;
        mem_ack = ack_now;
    end

    task automatic issue(input logic [15:0] l, input logic [31:0] a, input logic [3:0] br,
                         input bit ld, input bit u, input bit p, input bit w);
        int          n;
        int          t;
        logic [31:0] addr;
        logic [31:0] span;
        bit          wb_on;
        wr_t         writes[$];
        done_t       d;
        n    = $countones(l);
        span = 32'(4 * n);
        if (u) addr = p ? a + 32'd4 : a;
        else   addr = p ? a - span : a - span + 32'd4;
        for (int r = 0; r < 16; r++) begin
            if (l[r]) begin
                beat_q.push_back('{addr, !ld, 4'(r), ref_rf[r]});
                if (ld) writes.push_back('{4'(r), mem_val(addr)});
                addr = addr + 32'd4;
            end
        end
`ifdef REG_SEQ_WRITEBACK_EN
        wb_on = w && (n != 0) && !(ld && l[br]);
`else
        wb_on = w & 1'b0;
`endif
        if (wb_on) writes.push_back('{br, u ? a + span : a - span});
        foreach (writes[i]) begin
            wr_q.push_back(writes[i]);
            ref_rf[writes[i].num] = writes[i].data;
        end
        d.start_cnt = cycle_cnt;
        d.n         = n;
        done_q.push_back(d);
        reg_list  = l;
        base_addr = a;
        base_reg  = br;
        load      = ld;
        up        = u;
        pre       = p;
        wback     = w;
        start     = 1'b1;
        @(negedge clock);
        start     = 1'b0;
        reg_list  = 16'($urandom);
        base_addr = $urandom;
        base_reg  = 4'($urandom);
        t = 0;
        while (done_q.size() != 0 && t < 300) begin
            @(negedge clock);
            t++;
        end
        if (done_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=none expected=done");
            done_q.delete();
            beat_q.delete();
            wr_q.delete();
            waits = 0;
        end
        @(negedge clock);
    endtask

    initial begin
        logic [31:0] tmp;
        int          t;
        for (int i = 0; i < 16; i++) begin
            ref_rf[i] = 32'h1000_0000 + 32'(i) * 32'h111;
        end
        ref_rf[1] = 32'hA;
        ref_rf[2] = 32'hB;
        ref_rf[3] = 32'hC;
        env_rf    = ref_rf;

        repeat (3) @(negedge clock);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_rf_read_num", 32'(rf_read_num), 32'd0);
        check("rst_rf_write_en", 32'(rf_write_en), 32'd0);
        check("rst_rf_write_num", 32'(rf_write_num), 32'd0);
        check("rst_rf_write_data", rf_write_data, 32'd0);
        reset = 1'b1;
        @(negedge clock);

        ack_mode = 1;
        issue(16'h000E, 32'h1000, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);  // STMIA r0!, {r1-r3}
        issue(16'h0081, 32'h2000, 4'd4, 1'b1, 1'b0, 1'b1, 1'b1);  // LDMDB r4!, {r0,r7}
        issue(16'h0006, 32'h0300, 4'd2, 1'b1, 1'b1, 1'b0, 1'b1);  // LDMIA r2!, {r1,r2}
        ack_mode = 2;
        issue(16'h0008, 32'h0500, 4'd5, 1'b1, 1'b1, 1'b1, 1'b0);  // LDMIB r5, {r3}
        ack_mode = 0;
        issue(16'h0000, 32'h0800, 4'd1, 1'b0, 1'b1, 1'b0, 1'b1);  // empty list

        // Reset during the second beat of a 4-register STM.
        ack_mode  = 1;
        quiet     = 1'b1;
        reg_list  = 16'h001E;
        base_addr = 32'h4000;
        base_reg  = 4'd0;
        load      = 1'b0;
        up        = 1'b1;
        pre       = 1'b0;
        wback     = 1'b1;
        start     = 1'b1;
        @(negedge clock);
        start = 1'b0;
        t = 0;
        while (!(mem_req && mem_addr == 32'h4004) && t < 20) begin
            @(negedge clock);
            t++;
        end
        check("reach_second_beat", mem_addr, 32'h4004);
        reset = 1'b0;
        @(negedge clock);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_mem_req", 32'(mem_req), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_rf_write_en", 32'(rf_write_en), 32'd0);
        check("midrst_mem_addr", mem_addr, 32'd0);
        check("midrst_rf_read_num", 32'(rf_read_num), 32'd0);
        reset = 1'b1;
        waits = 0;
        quiet = 1'b0;
        repeat (4) @(negedge clock);
        issue(16'h001E, 32'h4000, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);

        for (int k = 0; k < 25; k++) begin
            tmp      = $urandom;
            ack_mode = $urandom_range(0, 1);
            issue(($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom), tmp & 32'hFFFF_FFFC,
                  4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end

        for (int i = 0; i < 16; i++) begin
            check("final_rf", env_rf[i], ref_rf[i]);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_list_sequencer.md
# reg_list_sequencer

Multi-cycle controller for ARM7TDMI block transfers (LDM/STM). It walks a 16-bit register list one register at a time and drives the register file read/write ports and a single-beat memory request/acknowledge interface. It then optionally writes the updated base address back. It sits between the decode stage and the register file and memory interface, and holds both for the duration of the instruction.

## Interface
- ADDR_W, 32, address width of base and memory address
- DATA_W, 32, register and memory data width
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  one-cycle command strobe; sampled only in IDLE
- reg_list  in  16  bit i set = transfer register ri
- base_addr  in  ADDR_W  current value of base register
- base_reg  in  4  base register number
- load  in  1  1 = LDM, 0 = STM
- up  in  1  U bit: 1 = increment, 0 = decrement
- pre  in  1  P bit: 1 = before, 0 = after
- wback  in  1  W bit: base writeback requested
- busy  out  1  high while a command is in progress
- done  out  1  one-cycle completion pulse
- mem_req  out  1  memory request, held until acknowledged
- mem_we  out  1  1 = write (STM)
- mem_addr  out  ADDR_W  word address of current beat
- mem_wdata  out  DATA_W  combinational copy of rf_read_data
- mem_rdata  in  DATA_W  load data, valid with mem_ack
- mem_ack  in  1  beat complete when mem_req && mem_ack at a rising edge
- rf_read_num  out  4  register being stored
- rf_read_data  in  DATA_W  register file read data
- rf_write_en  out  1  register file write strobe (registered)
- rf_write_num  out  4  register file write index
- rf_write_data  out  DATA_W  register file write data

## Operation
- States: IDLE, XFER, WB, FIN.
- IDLE: on start, latch all command inputs and n = popcount(reg_list), then go to XFER. If n = 0, go to WB with no beats.
- Start address (A = base_addr):
  - IA (pre=0, up=1): A
  - IB (pre=1, up=1): A+4
  - DA (pre=0, up=0): A−4n+4
  - DB (pre=1, up=0): A−4n
- Beats always run in ascending register number with ascending addresses (+4 per beat). Arithmetic is modulo 2^ADDR_W.
- Final base: up ? A+4n : A−4n.
- XFER:
  - Hold mem_req=1. mem_we = !load. mem_addr and rf_read_num point at the lowest unserviced register.
  - On ack, clear that list bit and advance the address.
  - If a load beat is acked, the next cycle has rf_write_en=1, rf_write_num = that register, rf_write_data = captured mem_rdata.
  - After the last ack, go to WB.
- WB: mem_req=0; one cycle. In this cycle the final load write is presented if the command was a load.
- FIN:
  - done=1 and busy=0.
  - If base writeback is active, rf_write_en=1, rf_write_num=base_reg, rf_write_data = final base.
  - Next state is IDLE.
- Base writeback is suppressed when wback=0, n=0, or (load=1 and reg_list[base_reg]=1), so the loaded value wins.
- STM containing base_reg stores the original base value. The register file is not written until FIN.
- start is ignored when not in IDLE.

## Timing
- Reset values:
  - busy=0, done=0, mem_req=0, mem_we=0, mem_addr=0
  - rf_read_num=0, rf_write_en=0, rf_write_num=0, rf_write_data=0
  - state=IDLE, latched list cleared
- mem_wdata follows rf_read_data combinationally at all times.
- busy rises the cycle after start is sampled and falls in the FIN cycle.
- mem_req rises the cycle after start. It stays high back-to-back across beats; mem_addr and rf_read_num change only in the cycle after an ack.
- Zero-wait memory (mem_ack tied high): done occurs n+2 cycles after the start edge.
- Each wait cycle (mem_req=1, mem_ack=0) adds exactly one cycle. Outputs are stable during waits.
- mem_ack while mem_req=0 is ignored.
- Reset low mid-operation:
  - The next cycle is IDLE with all outputs at reset values.
  - The outstanding beat is abandoned.
  - No rf write or done pulse is produced.

## Configuration
- REG_SEQ_WRITEBACK_EN defined: base writeback behaves as above.
- REG_SEQ_WRITEBACK_EN undefined:
  - wback is ignored and FIN never writes the register file.
  - WB and FIN still occur, so latency is unchanged.

## Test plan
- STMIA r0!, {r1,r2,r3}; base 0x1000, zero-wait; r1..r3 = 0xA,0xB,0xC -> writes 0xA@0x1000, 0xB@0x1004, 0xC@0x1008; FIN writes r0=0x100C; done 5 cycles after start.
- LDMDB r4!, {r0,r7}; base 0x2000; memory 0x1FF8=0x11, 0x1FFC=0x22 -> r0=0x11, r7=0x22, r4=0x1FF8; no overlapping rf writes.
- LDMIA r2!, {r1,r2}; base 0x300 -> r2 ends holding the loaded word from 0x304; no base writeback.
- LDMIB r5, {r3} with 3 wait cycles before ack -> mem_addr=0x(base+4) held stable; done at 1+3+2 cycles; no base write (wback=0).
- reg_list=0 with wback=1 -> no mem_req; done 2 cycles after start; no rf write.
- Reset asserted during the second beat of a 4-register STM -> next cycle busy=0 and mem_req=0; a start afterwards executes normally from its own start address.
